regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the single write port of register_file. Runs a post-reset init sequence (sp, gp), then
//  round-robin arbitrates ALU and LSU writeback requests onto one registered write port.
//  Sits between the execute/load units and register_file; write_* outputs feed its write port.
// PARAMETERS
//  DATA_WIDTH  32            write data width
//  ADDR_WIDTH  5             register address width
//  SP_INIT     32'h0000_1000 value written to x2 during init
//  GP_INIT     32'h0000_0800 value written to x3 during init
//  CNT_WIDTH   16            width of contention counter
// PORTS
//  clk           in   1           clock, all state on posedge
//  rst           in   1           synchronous reset, active-low
//  stall         in   1           core stall; blocks all grants while high
//  alu_valid     in   1           ALU writeback request
//  alu_ready     out  1           ALU request accepted this cycle
//  alu_addr      in   ADDR_WIDTH  ALU destination register
//  alu_data      in   DATA_WIDTH  ALU result
//  lsu_valid     in   1           load writeback request
//  lsu_ready     out  1           load request accepted this cycle
//  lsu_addr      in   ADDR_WIDTH  load destination register
//  lsu_data      in   DATA_WIDTH  load data
//  write_enable  out  1           to register_file write_enable
//  write_addr    out  ADDR_WIDTH  to register_file write_addr
//  write_data    out  DATA_WIDTH  to register_file write_data
//  init_done     out  1           high once init sequence complete
//  conflict_cnt  out  CNT_WIDTH   saturating count of cycles with a valid, non-ready requester
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=INIT_SP, write_enable=0, write_addr=0, write_data=0,
//   init_done=0, conflict_cnt=0, rr_ptr=0 (ALU preferred). An accepted write not yet on the
//   port is dropped. Reset overrides everything, including mid-init and mid-handshake.
//  FSM: INIT_SP -> INIT_GP -> RUN; each INIT state lasts exactly 1 cycle, ignores stall.
//   INIT_SP registers {en=1,addr=2,data=SP_INIT}; INIT_GP registers {en=1,addr=3,data=GP_INIT}.
//   init_done rises on the edge entering RUN: 2nd posedge after reset release.
//   RUN is terminal until reset. Both readys are 0 outside RUN.
//  Ready (combinational): only in RUN with stall==0.
//   One valid -> that requester granted. Both valid -> rr_ptr picks (0=ALU, 1=LSU).
//   Never both readys in one cycle.
//  rr_ptr <= granted requester's complement on each grant (last winner loses next tie).
//   Unchanged when no grant.
//  Handshake: transfer when valid&&ready at posedge. Requester holds valid/addr/data stable
//   until then. Valid may drop without transfer; no state is kept for it.
//  Latency: transfer at edge N -> write_* registered at edge N -> register_file writes at N+1.
//   No internal buffer, so a new grant is possible every cycle.
//  x0: a transfer with addr==0 completes normally (ready high) but registers write_enable=0.
//  Idle cycle (no transfer, RUN): write_enable<=0; write_addr/write_data hold previous values.
//  conflict_cnt: +1 each RUN cycle where (alu_valid&&!alu_ready)||(lsu_valid&&!lsu_ready),
//   including stall cycles. Saturates at all-ones, never wraps.
// TESTING
//  1 Reset, release: cyc1 write x2=00001000, cyc2 write x3=00000800, init_done=1 after 2nd edge;
//    readys 0 during init even if valids high.
//  2 ALU-only x5=12345678: alu_ready same cycle; write_enable/x5/12345678 next cycle;
//    register_file read of x5 returns 12345678.
//  3 Both valid held 4 cycles (ALU x6=A, LSU x7=B) -> grants ALU,LSU,ALU,LSU;
//    conflict_cnt +1 per cycle where one loser exists.
//  4 stall=1 with both valid 3 cycles -> no readys, write_enable=0, conflict_cnt+=3;
//    release -> grant per rr_ptr.
//  5 LSU write x0=DEADBEEF -> lsu_ready=1, write_enable stays 0, x0 reads 0.
//  6 Drop rst mid-RUN with pending grant -> write dropped, outputs zeroed, init replays;
//    force 2^CNT_WIDTH+5 conflict cycles -> counter holds FFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bundle between the execute/load units, the arbiter and register_file.
// The arbiter uses the slave side; requesters and status consumers use the master side.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  stall;
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_addr;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_addr;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  init_done;
    logic [CNT_WIDTH-1:0]  conflict_cnt;

    modport master (
        output stall, alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
        input  alu_ready, lsu_ready, write_enable, write_addr, write_data,
               init_done, conflict_cnt
    );

    modport slave (
        input  stall, alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
        output alu_ready, lsu_ready, write_enable, write_addr, write_data,
               init_done, conflict_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Sole owner of the register_file write port: writes sp/gp after reset, then
// round-robin arbitrates ALU and LSU writebacks onto one registered write port.
module regfile_wb_arbiter #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0000_1000,
    parameter logic [DATA_WIDTH-1:0] GP_INIT    = 32'h0000_0800,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  wb_if
);

    typedef enum logic [1:0] {
        INIT_SP,
        INIT_GP,
        RUN
    } state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  init_done_q, init_done_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  rr_q, rr_d;
    logic                  canGrant;
    logic                  aluGrant;
    logic                  lsuGrant;
    logic                  conflict;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= INIT_SP;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
        end
    end

    // rr_q names the requester that wins a tie: 0 = ALU, 1 = LSU.
    always_comb begin
        canGrant = (state_q == RUN) && !wb_if.stall;
        aluGrant = canGrant && wb_if.alu_valid && (!wb_if.lsu_valid || !rr_q);
        lsuGrant = canGrant && wb_if.lsu_valid && (!wb_if.alu_valid || rr_q);
        conflict = (wb_if.alu_valid && !aluGrant) || (wb_if.lsu_valid && !lsuGrant);

        state_d     = state_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        init_done_d = init_done_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;

        unique case (state_q)
            INIT_SP: begin
                we_d    = 1'b1;
                waddr_d = ADDR_WIDTH'(2);
                wdata_d = SP_INIT;
                state_d = INIT_GP;
            end
            INIT_GP: begin
                we_d        = 1'b1;
                waddr_d     = ADDR_WIDTH'(3);
                wdata_d     = GP_INIT;
                state_d     = RUN;
                init_done_d = 1'b1;
            end
            RUN: begin
                if (aluGrant) begin
                    we_d    = (wb_if.alu_addr != '0);
                    waddr_d = wb_if.alu_addr;
                    wdata_d = wb_if.alu_data;
                    rr_d    = 1'b1;
                end else if (lsuGrant) begin
                    we_d    = (wb_if.lsu_addr != '0);
                    waddr_d = wb_if.lsu_addr;
                    wdata_d = wb_if.lsu_data;
                    rr_d    = 1'b0;
                end
                if (conflict && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                    cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = INIT_SP;
            end
        endcase
    end

    assign wb_if.alu_ready    = aluGrant;
    assign wb_if.lsu_ready    = lsuGrant;
    assign wb_if.write_enable = we_q;
    assign wb_if.write_addr   = waddr_q;
    assign wb_if.write_data   = wdata_q;
    assign wb_if.init_done    = init_done_q;
    assign wb_if.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected register writes go into a queue
// and a negedge monitor pops and compares them whenever write_enable is high.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   checkCount;
    int   failCount;
    int   expCnt;
    wr_t  expQ[$];

    regfile_wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) wb_if ();

    regfile_wb_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .SP_INIT   (32'h0000_1000),
        .GP_INIT   (32'h0000_0800),
        .CNT_WIDTH (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .wb_if(wb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                 input logic st);
        wb_if.alu_valid = av;
        wb_if.alu_addr  = aa;
        wb_if.alu_data  = ad;
        wb_if.lsu_valid = lv;
        wb_if.lsu_addr  = la;
        wb_if.lsu_data  = ld;
        wb_if.stall     = st;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkReadys(input string name, input logic expAlu, input logic expLsu);
        @(negedge clk);
        checkOutput({name, "_alu_ready"}, 32'(wb_if.alu_ready), 32'(expAlu));
        checkOutput({name, "_lsu_ready"}, 32'(wb_if.lsu_ready), 32'(expLsu));
    endtask

    task automatic pushWrite(input logic [4:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        expQ.push_back(w);
    endtask

    // Every registered write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wb_if.write_enable === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write_addr", 32'(wb_if.write_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = expQ.pop_front();
                checkOutput("write_addr", 32'(wb_if.write_addr), 32'(w.addr));
                checkOutput("write_data", wb_if.write_data, w.data);
            end
        end
    end

    initial begin
        #2_000_000;
        failCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        checkCount = 0;
        failCount  = 0;
        expCnt     = 0;
        rst        = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_write_enable", 32'(wb_if.write_enable), 32'h0);
        checkOutput("rst_write_addr", 32'(wb_if.write_addr), 32'h0);
        checkOutput("rst_write_data", wb_if.write_data, 32'h0);
        checkOutput("rst_init_done", 32'(wb_if.init_done), 32'h0);
        checkOutput("rst_conflict_cnt", 32'(wb_if.conflict_cnt), 32'h0);

        // Release reset with both requesters already asking; init must ignore them.
        tick();
        rst = 1'b1;
        pushWrite(5'd2, 32'h0000_1000);
        pushWrite(5'd3, 32'h0000_0800);
        applyStimulus(1'b1, 5'd6, 32'h0000_000A, 1'b1, 5'd7, 32'h0000_000B, 1'b0);
        checkReadys("init_sp", 1'b0, 1'b0);
        tick();
        checkReadys("init_gp", 1'b0, 1'b0);
        checkOutput("init_done_mid", 32'(wb_if.init_done), 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("init_done_run", 32'(wb_if.init_done), 32'h1);
        checkOutput("cnt_after_init", 32'(wb_if.conflict_cnt), 32'h0);

        // Single ALU request, then a single LSU request to leave the tie pointer on ALU.
        tick();
        applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 1'b0);
        pushWrite(5'd5, 32'h1234_5678);
        checkReadys("alu_only", 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hCAFE_F00D, 1'b0);
        pushWrite(5'd4, 32'hCAFE_F00D);
        checkReadys("lsu_only", 1'b0, 1'b1);
        tick();

        // Both requesting for four cycles: ALU, LSU, ALU, LSU, one loser each cycle.
        applyStimulus(1'b1, 5'd6, 32'h0000_000A, 1'b1, 5'd7, 32'h0000_000B, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) pushWrite(5'd6, 32'h0000_000A);
            else            pushWrite(5'd7, 32'h0000_000B);
            checkReadys($sformatf("tie%0d", i), (i % 2 == 0), (i % 2 == 1));
            tick();
            expCnt++;
        end
        checkOutput("cnt_after_tie", 32'(wb_if.conflict_cnt), 32'(expCnt));

        // Stall with both valid: no grants, but each cycle still counts as contention.
        applyStimulus(1'b1, 5'd6, 32'h0000_000A, 1'b1, 5'd7, 32'h0000_000B, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkReadys($sformatf("stall%0d", i), 1'b0, 1'b0);
            tick();
            expCnt++;
        end
        checkOutput("stall_write_enable", 32'(wb_if.write_enable), 32'h0);
        checkOutput("cnt_after_stall", 32'(wb_if.conflict_cnt), 32'(expCnt));
        wb_if.stall = 1'b0;
        pushWrite(5'd6, 32'h0000_000A);
        checkReadys("unstall", 1'b1, 1'b0);
        tick();
        expCnt++;
        checkOutput("cnt_after_unstall", 32'(wb_if.conflict_cnt), 32'(expCnt));

        // Writes to x0 complete the handshake but never reach the register file.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
        checkReadys("x0", 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("x0_write_enable", 32'(wb_if.write_enable), 32'h0);

        // Reset lands on the same edge as a grant: the write is lost and init replays.
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 5'd9, 32'h1111_1111, 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("rst2_write_enable", 32'(wb_if.write_enable), 32'h0);
        checkOutput("rst2_write_addr", 32'(wb_if.write_addr), 32'h0);
        checkOutput("rst2_write_data", wb_if.write_data, 32'h0);
        checkOutput("rst2_init_done", 32'(wb_if.init_done), 32'h0);
        checkOutput("rst2_conflict_cnt", 32'(wb_if.conflict_cnt), 32'h0);
        tick();
        rst = 1'b1;
        pushWrite(5'd2, 32'h0000_1000);
        pushWrite(5'd3, 32'h0000_0800);
        tick();
        tick();
        checkOutput("rst2_init_done_run", 32'(wb_if.init_done), 32'h1);

        // Hold contention past 2^16 cycles; the counter must stick at all-ones.
        applyStimulus(1'b1, 5'd6, 32'h0000_000A, 1'b1, 5'd7, 32'h0000_000B, 1'b1);
        for (int n = 1; n <= 65541; n++) begin
            tick();
            if (n == 65534) checkOutput("cnt_near_sat", 32'(wb_if.conflict_cnt), 32'h0000_FFFE);
            if (n == 65535) checkOutput("cnt_at_sat", 32'(wb_if.conflict_cnt), 32'h0000_FFFF);
        end
        checkOutput("cnt_saturated", 32'(wb_if.conflict_cnt), 32'h0000_FFFF);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("pending_writes_left", 32'(expQ.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
